volatility_addr_gen: RTL and testbench

Address generator for the per-stock price history RAM that feeds the volatility engine. The RAM holds NUM_STOCKS × BUFFER_SIZE words.
- Write side: for each incoming price it issues a circular write address inside that stock's region. The active window length is set at runtime.
- Read side: it tracks per-stock fill level, and on request sweeps that stock's stored window oldest-to-newest. The volatility datapath consumes these read addresses.
- It generalises the earlier write-only controller: runtime clamped window, fill tracking, flush, and a read-sweep FSM.

---
 rtl/volatility_addr_gen.sv | 175 +++++++++++++++++
 tb/tb_volatility_addr_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/volatility_addr_gen.sv
// Address generator for the per-stock price history RAM.
// Write side: circular write address per stock inside a runtime-clamped window.
// Read side: fill tracking plus a sweep FSM that walks a stock's stored
// window oldest-to-newest, one read address per cycle.
//
// Handshake: o_addr_valid / o_rd_valid qualify their address for exactly the
// cycle they are high; there is no ready/back-pressure on either side, so a
// consumer must accept every qualified address in the cycle it is presented.
module volatility_addr_gen #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32,
    localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE),
    localparam int OW = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [SW-1:0]         i_stock_id,
    input  logic                  i_data_valid,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_buffer_size,
    input  logic                  i_rd_req,
    input  logic [SW-1:0]         i_rd_stock_id,
    output logic [AW-1:0]         o_write_address,
    output logic                  o_addr_valid,
    output logic [AW-1:0]         o_rd_address,
    output logic                  o_rd_valid,
    output logic                  o_rd_last,
    output logic                  o_rd_done,
    output logic                  o_rd_busy,
    output logic [NUM_STOCKS-1:0] o_window_full
);

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_SWEEP = 2'd1,
        RD_DONE  = 2'd2
    } rd_state_t;

    // Base address of a stock's region; constant multiply.
    function automatic logic [AW-1:0] stock_base(input logic [SW-1:0] s);
        return AW'(int'(s) * BUFFER_SIZE);
    endfunction

    logic [OW-1:0] wr_ptr [NUM_STOCKS];
    logic [OW-1:0] fill   [NUM_STOCKS];
    logic [OW-1:0] weff;

    logic [OW-1:0] cur_ptr, cur_fill, wr_off, off_inc, nxt_ptr, fill_sat, nxt_fill;

    // Read sweep state; rd_state is the observable FSM state.
    rd_state_t     rd_state, rd_state_nxt;
    logic [SW-1:0] rd_stock;
    logic [OW-1:0] rd_cnt, rd_idx, rd_off, rd_ws;
    logic [OW-1:0] snap_fill, snap_start, rd_off_inc;

    // Clamp the requested window to [2, BUFFER_SIZE] at full input width.
    always_comb begin
        if (i_buffer_size < DATA_WIDTH'(2))
            weff = OW'(2);
        else if (i_buffer_size > DATA_WIDTH'(BUFFER_SIZE))
            weff = OW'(BUFFER_SIZE);
        else
            weff = i_buffer_size[OW-1:0];
    end

    // Write offset and pointer/fill update; a same-cycle flush is applied first.
    always_comb begin
        cur_ptr  = i_flush ? '0 : wr_ptr[i_stock_id];
        cur_fill = i_flush ? '0 : fill[i_stock_id];
        wr_off   = (cur_ptr < weff) ? cur_ptr : '0;
        off_inc  = wr_off + OW'(1);
        nxt_ptr  = (off_inc == weff) ? '0 : off_inc;
        fill_sat = (cur_fill < weff) ? cur_fill : weff;
        nxt_fill = (fill_sat < weff) ? fill_sat + OW'(1) : weff;
    end

    // Registered write address plus per-stock pointer and fill state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int s = 0; s < NUM_STOCKS; s++) begin
                wr_ptr[s] <= '0;
                fill[s]   <= '0;
            end
            o_addr_valid    <= 1'b0;
            o_write_address <= '0;
        end else begin
            o_addr_valid <= i_data_valid;
            if (i_data_valid) begin
                o_write_address    <= stock_base(i_stock_id) + AW'(wr_off);
                wr_ptr[i_stock_id] <= nxt_ptr;
                fill[i_stock_id]   <= nxt_fill;
            end else if (i_flush) begin
                wr_ptr[i_stock_id] <= '0;
                fill[i_stock_id]   <= '0;
            end
        end
    end

    // A stock's window is full when its fill matches the current effective window.
    always_comb begin
        o_window_full = '0;
        for (int s = 0; s < NUM_STOCKS; s++)
            o_window_full[s] = (fill[s] == weff);
    end

    // Snapshot values for a sweep request: stored count and oldest entry offset.
    always_comb begin
        snap_fill  = (fill[i_rd_stock_id] < weff) ? fill[i_rd_stock_id] : weff;
        snap_start = (snap_fill == weff) ? (wr_ptr[i_rd_stock_id] % weff) : '0;
        rd_off_inc = rd_off + OW'(1);
    end

    // Sweep FSM state register and snapshot/iteration registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_state <= RD_IDLE;
            rd_stock <= '0;
            rd_cnt   <= '0;
            rd_idx   <= '0;
            rd_off   <= '0;
            rd_ws    <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            case (rd_state)
                RD_IDLE: begin
                    if (i_rd_req) begin
                        rd_stock <= i_rd_stock_id;
                        rd_cnt   <= snap_fill;
                        rd_ws    <= weff;
                        rd_off   <= snap_start;
                        rd_idx   <= '0;
                    end
                end
                RD_SWEEP: begin
                    rd_idx <= rd_idx + OW'(1);
                    rd_off <= (rd_off_inc == rd_ws) ? '0 : rd_off_inc;
                end
                default: ;
            endcase
        end
    end

    // Sweep FSM next state and read-side outputs.
    always_comb begin
        rd_state_nxt = rd_state;
        o_rd_address = '0;
        o_rd_valid   = 1'b0;
        o_rd_last    = 1'b0;
        o_rd_done    = 1'b0;
        o_rd_busy    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (i_rd_req)
                    rd_state_nxt = (snap_fill != '0) ? RD_SWEEP : RD_DONE;
            end
            RD_SWEEP: begin
                o_rd_valid   = 1'b1;
                o_rd_busy    = 1'b1;
                o_rd_address = stock_base(rd_stock) + AW'(rd_off);
                o_rd_last    = ((rd_idx + OW'(1)) == rd_cnt);
                if (o_rd_last)
                    rd_state_nxt = RD_DONE;
            end
            RD_DONE: begin
                o_rd_done    = 1'b1;
                o_rd_busy    = 1'b1;
                rd_state_nxt = RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_volatility_addr_gen.sv
// Directed testbench for volatility_addr_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_volatility_addr_gen;

    localparam int NUM_STOCKS  = 4;
    localparam int BUFFER_SIZE = 20;
    localparam int DATA_WIDTH  = 32;
    localparam int SW = 2;
    localparam int AW = 7;

    logic                  i_clk = 1'b0;
    logic                  i_reset_n;
    logic [SW-1:0]         i_stock_id;
    logic                  i_data_valid;
    logic                  i_flush;
    logic [DATA_WIDTH-1:0] i_buffer_size;
    logic                  i_rd_req;
    logic [SW-1:0]         i_rd_stock_id;
    logic [AW-1:0]         o_write_address;
    logic                  o_addr_valid;
    logic [AW-1:0]         o_rd_address;
    logic                  o_rd_valid;
    logic                  o_rd_last;
    logic                  o_rd_done;
    logic                  o_rd_busy;
    logic [NUM_STOCKS-1:0] o_window_full;

    int tests_run    = 0;
    int tests_failed = 0;

    volatility_addr_gen #(
        .NUM_STOCKS (NUM_STOCKS),
        .BUFFER_SIZE(BUFFER_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_stock_id     (i_stock_id),
        .i_data_valid   (i_data_valid),
        .i_flush        (i_flush),
        .i_buffer_size  (i_buffer_size),
        .i_rd_req       (i_rd_req),
        .i_rd_stock_id  (i_rd_stock_id),
        .o_write_address(o_write_address),
        .o_addr_valid   (o_addr_valid),
        .o_rd_address   (o_rd_address),
        .o_rd_valid     (o_rd_valid),
        .o_rd_last      (o_rd_last),
        .o_rd_done      (o_rd_done),
        .o_rd_busy      (o_rd_busy),
        .o_window_full  (o_window_full)
    );

    // Clock and watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_stock_id    = '0;
        i_data_valid  = 1'b0;
        i_flush       = 1'b0;
        i_rd_req      = 1'b0;
        i_rd_stock_id = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_buffer_size = 32'd4;
        i_reset_n     = 1'b0;
        step();
        step();
        tests_run++; if (o_write_address !== '0) begin tests_failed++; $display("FAIL reset_waddr: got %0d expected 0", o_write_address); end
        tests_run++; if (o_addr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_avalid: got %b expected 0", o_addr_valid); end
        tests_run++; if (o_rd_address !== '0) begin tests_failed++; $display("FAIL reset_raddr: got %0d expected 0", o_rd_address); end
        tests_run++; if (o_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 0", o_rd_valid); end
        tests_run++; if (o_rd_last !== 1'b0) begin tests_failed++; $display("FAIL reset_rlast: got %b expected 0", o_rd_last); end
        tests_run++; if (o_rd_done !== 1'b0) begin tests_failed++; $display("FAIL reset_rdone: got %b expected 0", o_rd_done); end
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_rbusy: got %b expected 0", o_rd_busy); end
        tests_run++; if (o_window_full !== 4'b0000) begin tests_failed++; $display("FAIL reset_wfull: got %b expected 0000", o_window_full); end
        i_reset_n = 1'b1;
        step();
    endtask

    // W=4, stock 2, six writes: 40,41,42,43,40,41; full after the 4th.
    task automatic test_write_wrap();
        int   exp_a [6] = '{40, 41, 42, 43, 40, 41};
        logic exp_full;
        i_buffer_size = 32'd4;
        i_stock_id    = 2'd2;
        for (int k = 0; k < 6; k++) begin
            i_data_valid = 1'b1;
            step();
            exp_full = (k >= 3);
            tests_run++; if (o_addr_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_avalid[%0d]: got %b expected 1", k, o_addr_valid); end
            tests_run++; if (o_write_address !== AW'(exp_a[k])) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, o_write_address, exp_a[k]); end
            tests_run++; if (o_window_full[2] !== exp_full) begin tests_failed++; $display("FAIL wrap_full[%0d]: got %b expected %b", k, o_window_full[2], exp_full); end
        end
        i_data_valid = 1'b0;
        step();
        tests_run++; if (o_addr_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_idle_avalid: got %b expected 0", o_addr_valid); end
    endtask

    // W=3, stock 1, five writes (ptr ends at 2, full) -> sweep 22,20,21.
    task automatic test_read_sweep();
        int   exp_r [3] = '{22, 20, 21};
        logic exp_last;
        i_buffer_size = 32'd3;
        i_stock_id    = 2'd1;
        for (int k = 0; k < 5; k++) begin
            i_data_valid = 1'b1;
            step();
        end
        i_data_valid  = 1'b0;
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd1;
        step();
        i_rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_last = (i == 2);
            tests_run++; if (o_rd_valid !== 1'b1) begin tests_failed++; $display("FAIL sweep_rvalid[%0d]: got %b expected 1", i, o_rd_valid); end
            tests_run++; if (o_rd_address !== AW'(exp_r[i])) begin tests_failed++; $display("FAIL sweep_raddr[%0d]: got %0d expected %0d", i, o_rd_address, exp_r[i]); end
            tests_run++; if (o_rd_last !== exp_last) begin tests_failed++; $display("FAIL sweep_rlast[%0d]: got %b expected %b", i, o_rd_last, exp_last); end
            step();
        end
        tests_run++; if (o_rd_done !== 1'b1) begin tests_failed++; $display("FAIL sweep_done: got %b expected 1", o_rd_done); end
        tests_run++; if (o_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL sweep_done_rvalid: got %b expected 0", o_rd_valid); end
        step();
        tests_run++; if (o_rd_done !== 1'b0) begin tests_failed++; $display("FAIL sweep_done_pulse: got %b expected 0", o_rd_done); end
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL sweep_busy_end: got %b expected 0", o_rd_busy); end
    endtask

    // W=20, stock 0, two writes -> sweep 0,1; empty stock 3 -> done only.
    task automatic test_partial_and_empty();
        logic exp_last;
        i_buffer_size = 32'd20;
        i_stock_id    = 2'd0;
        for (int k = 0; k < 2; k++) begin
            i_data_valid = 1'b1;
            step();
        end
        i_data_valid  = 1'b0;
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd0;
        step();
        i_rd_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_last = (i == 1);
            tests_run++; if (o_rd_valid !== 1'b1) begin tests_failed++; $display("FAIL part_rvalid[%0d]: got %b expected 1", i, o_rd_valid); end
            tests_run++; if (o_rd_address !== AW'(i)) begin tests_failed++; $display("FAIL part_raddr[%0d]: got %0d expected %0d", i, o_rd_address, i); end
            tests_run++; if (o_rd_last !== exp_last) begin tests_failed++; $display("FAIL part_rlast[%0d]: got %b expected %b", i, o_rd_last, exp_last); end
            step();
        end
        tests_run++; if (o_rd_done !== 1'b1) begin tests_failed++; $display("FAIL part_done: got %b expected 1", o_rd_done); end
        step();
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd3;
        step();
        i_rd_req = 1'b0;
        tests_run++; if (o_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_rvalid: got %b expected 0", o_rd_valid); end
        tests_run++; if (o_rd_done !== 1'b1) begin tests_failed++; $display("FAIL empty_done: got %b expected 1", o_rd_done); end
        tests_run++; if (o_rd_busy !== 1'b1) begin tests_failed++; $display("FAIL empty_busy: got %b expected 1", o_rd_busy); end
        step();
        tests_run++; if (o_rd_done !== 1'b0) begin tests_failed++; $display("FAIL empty_done_pulse: got %b expected 0", o_rd_done); end
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL empty_busy_end: got %b expected 0", o_rd_busy); end
    endtask

    // Clamp: size 0 acts as W=2, size 0xFFFFFFFF acts as W=20.
    task automatic test_clamp();
        int   exp_a [3] = '{0, 1, 0};
        logic exp_full;
        i_buffer_size = 32'd0;
        i_stock_id    = 2'd0;
        i_flush       = 1'b1;
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_data_valid = 1'b1;
            step();
            exp_full = (k >= 1);
            tests_run++; if (o_write_address !== AW'(exp_a[k])) begin tests_failed++; $display("FAIL clamp_lo_addr[%0d]: got %0d expected %0d", k, o_write_address, exp_a[k]); end
            tests_run++; if (o_window_full[0] !== exp_full) begin tests_failed++; $display("FAIL clamp_lo_full[%0d]: got %b expected %b", k, o_window_full[0], exp_full); end
        end
        i_data_valid  = 1'b0;
        i_buffer_size = 32'hFFFF_FFFF;
        i_flush       = 1'b1;
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 21; k++) begin
            i_data_valid = 1'b1;
            step();
            exp_full = (k >= 19);
            tests_run++; if (o_write_address !== AW'(k % 20)) begin tests_failed++; $display("FAIL clamp_hi_addr[%0d]: got %0d expected %0d", k, o_write_address, k % 20); end
            tests_run++; if (o_window_full[0] !== exp_full) begin tests_failed++; $display("FAIL clamp_hi_full[%0d]: got %b expected %b", k, o_window_full[0], exp_full); end
        end
        i_data_valid = 1'b0;
        step();
    endtask

    // Same-cycle flush+write on stock 2 with wr_ptr=3; then a request held high while busy.
    task automatic test_flush_and_busy();
        int   exp_r [3] = '{22, 20, 21};
        logic exp_last;
        i_buffer_size = 32'd4;
        i_stock_id    = 2'd2;
        i_flush       = 1'b1;
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_data_valid = 1'b1;
            step();
            tests_run++; if (o_write_address !== AW'(40 + k)) begin tests_failed++; $display("FAIL flush_pre_addr[%0d]: got %0d expected %0d", k, o_write_address, 40 + k); end
        end
        i_flush = 1'b1;
        step();
        i_flush      = 1'b0;
        i_data_valid = 1'b0;
        tests_run++; if (o_write_address !== AW'(40)) begin tests_failed++; $display("FAIL flush_wr_addr: got %0d expected 40", o_write_address); end
        tests_run++; if (o_addr_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_wr_avalid: got %b expected 1", o_addr_valid); end
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd2;
        step();
        i_rd_req = 1'b0;
        tests_run++; if (o_rd_address !== AW'(40)) begin tests_failed++; $display("FAIL flush_rd_addr: got %0d expected 40", o_rd_address); end
        tests_run++; if (o_rd_last !== 1'b1) begin tests_failed++; $display("FAIL flush_rd_last (fill 1): got %b expected 1", o_rd_last); end
        step();
        tests_run++; if (o_rd_done !== 1'b1) begin tests_failed++; $display("FAIL flush_rd_done: got %b expected 1", o_rd_done); end
        step();
        i_buffer_size = 32'd3;
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd1;
        step();
        for (int i = 0; i < 3; i++) begin
            exp_last = (i == 2);
            tests_run++; if (o_rd_address !== AW'(exp_r[i])) begin tests_failed++; $display("FAIL busy_raddr[%0d]: got %0d expected %0d", i, o_rd_address, exp_r[i]); end
            tests_run++; if (o_rd_last !== exp_last) begin tests_failed++; $display("FAIL busy_rlast[%0d]: got %b expected %b", i, o_rd_last, exp_last); end
            step();
        end
        tests_run++; if (o_rd_done !== 1'b1) begin tests_failed++; $display("FAIL busy_done: got %b expected 1", o_rd_done); end
        step();
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_ignored_busy: got %b expected 0", o_rd_busy); end
        tests_run++; if (o_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL busy_ignored_rvalid: got %b expected 0", o_rd_valid); end
        i_rd_req = 1'b0;
        step();
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_after_busy: got %b expected 0", o_rd_busy); end
    endtask

    // Reset in the middle of a sweep aborts it without a done pulse.
    task automatic test_reset_mid_sweep();
        i_buffer_size = 32'd3;
        i_rd_req      = 1'b1;
        i_rd_stock_id = 2'd1;
        step();
        i_rd_req = 1'b0;
        tests_run++; if (o_rd_address !== AW'(22)) begin tests_failed++; $display("FAIL mid_raddr: got %0d expected 22", o_rd_address); end
        i_reset_n = 1'b0;
        step();
        tests_run++; if (o_write_address !== '0) begin tests_failed++; $display("FAIL mid_waddr: got %0d expected 0", o_write_address); end
        tests_run++; if (o_addr_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_avalid: got %b expected 0", o_addr_valid); end
        tests_run++; if (o_rd_address !== '0) begin tests_failed++; $display("FAIL mid_raddr_rst: got %0d expected 0", o_rd_address); end
        tests_run++; if (o_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rvalid: got %b expected 0", o_rd_valid); end
        tests_run++; if (o_rd_last !== 1'b0) begin tests_failed++; $display("FAIL mid_rlast: got %b expected 0", o_rd_last); end
        tests_run++; if (o_rd_done !== 1'b0) begin tests_failed++; $display("FAIL mid_rdone: got %b expected 0", o_rd_done); end
        tests_run++; if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rbusy: got %b expected 0", o_rd_busy); end
        tests_run++; if (o_window_full !== 4'b0000) begin tests_failed++; $display("FAIL mid_wfull: got %b expected 0000", o_window_full); end
        i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++; if (o_rd_done !== 1'b0) begin tests_failed++; $display("FAIL mid_no_done[%0d]: got %b expected 0", k, o_rd_done); end
        end
        i_buffer_size = 32'd4;
        i_stock_id    = 2'd0;
        i_data_valid  = 1'b1;
        step();
        i_data_valid = 1'b0;
        tests_run++; if (o_write_address !== '0) begin tests_failed++; $display("FAIL mid_first_waddr: got %0d expected 0", o_write_address); end
        tests_run++; if (o_addr_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_first_avalid: got %b expected 1", o_addr_valid); end
        step();
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_buffer_size = '0;
        idle_inputs();
        test_reset();
        test_write_wrap();
        test_read_sweep();
        test_partial_and_empty();
        test_clamp();
        test_flush_and_busy();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
